pipeline_ctrl: RTL

Parametrised pipeline control unit, successor to the fixed 4-stage stall/flush controller. It generalises stall generation to STAGES stages, each with its own stall request. It turns the exception redirect into a sequenced operation: a multi-cycle flush, then a redirect to fetch with a valid/ready handshake. It sits beside the pipeline, takes stall requests from every stage and the committed exception type from the commit stage, and drives stall, flush and the fetch redirect.

---
 rtl/pipeline_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline control: per-stage stall generation, multi-cycle exception flush,
// and a valid/ready redirect of the exception/ERET target to fetch.
module pipeline_ctrl #(
    parameter int STAGES       = 4,
    parameter int ADDR_W       = 32,
    parameter int EXC_W        = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [STAGES-1:0] stall_req,
    input  logic [EXC_W-1:0]  exception_type_i,
    input  logic [ADDR_W-1:0] latest_cp0_reg_epc,
    input  logic [ADDR_W-1:0] latest_cp0_reg_ebase,
    input  logic              fetch_ready,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [EXC_W-1:0] EXC_INT       = EXC_W'(32'h0000_0001);
    localparam logic [EXC_W-1:0] EXC_ADEL      = EXC_W'(32'h0000_0004);
    localparam logic [EXC_W-1:0] EXC_ADES      = EXC_W'(32'h0000_0005);
    localparam logic [EXC_W-1:0] EXC_SYS       = EXC_W'(32'h0000_0008);
    localparam logic [EXC_W-1:0] EXC_BREAK     = EXC_W'(32'h0000_0009);
    localparam logic [EXC_W-1:0] EXC_INSTVALID = EXC_W'(32'h0000_000a);
    localparam logic [EXC_W-1:0] EXC_OV        = EXC_W'(32'h0000_000c);
    localparam logic [EXC_W-1:0] EXC_ERET      = EXC_W'(32'h0000_000e);

    // The IDLE cycle accounts for one flush cycle, hence the -2 preload.
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_flush_cnt;
    logic [ADDR_W-1:0]   r_redirect_pc;
    logic                r_redirect_valid;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                w_exc;
    logic [STAGES-1:0]   w_stall_mask;
    logic [ADDR_W-1:0]   w_target;
    logic                w_cnt_inc;

    // A stall at stage k must also hold every younger stage below it.
    function automatic logic [STAGES-1:0] stall_mask(input logic [STAGES-1:0] req);
        logic [STAGES-1:0] m;
        logic              acc;
        m   = '0;
        acc = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc  = acc | req[i];
            m[i] = acc;
        end
        return m;
    endfunction

    function automatic logic [ADDR_W-1:0] exc_target(input logic [EXC_W-1:0] code,
                                                     input logic [ADDR_W-1:0] epc,
                                                     input logic [ADDR_W-1:0] ebase);
        logic [ADDR_W-1:0] t;
        t = '0;
        case (code)
            EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
            EXC_BREAK, EXC_INSTVALID, EXC_OV: t = ebase;
            EXC_ERET:                          t = epc;
            default:                           t = '0;
        endcase
        return t;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign w_exc        = (exception_type_i != '0);
    assign w_stall_mask = stall_mask(stall_req);
    assign w_target     = exc_target(exception_type_i, latest_cp0_reg_epc, latest_cp0_reg_ebase);

    always_comb begin
        w_next_state = r_state;
        stall        = '0;
        flush        = 1'b0;
        w_cnt_inc    = 1'b0;
        if (resetn) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_exc) begin
                        flush        = 1'b1;
                        w_next_state = (FLUSH_CYCLES == 1) ? ST_REDIRECT : ST_FLUSH;
                    end else begin
                        stall     = w_stall_mask;
                        w_cnt_inc = (w_stall_mask != '0);
                    end
                end
                ST_FLUSH: begin
                    flush = 1'b1;
                    if (r_flush_cnt == 4'd0) begin
                        w_next_state = ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    stall = '1;
                    if (fetch_ready) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state          <= ST_IDLE;
            r_flush_cnt      <= 4'd0;
            r_redirect_pc    <= '0;
            r_redirect_valid <= 1'b0;
            r_stall_cnt      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_cnt_inc) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_exc) begin
                        r_redirect_pc <= w_target;
                        r_flush_cnt   <= FLUSH_LOAD;
                        if (FLUSH_CYCLES == 1) begin
                            r_redirect_valid <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == 4'd0) begin
                        r_redirect_valid <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                ST_REDIRECT: begin
                    if (fetch_ready) begin
                        r_redirect_valid <= 1'b0;
                    end
                end
                default: r_redirect_valid <= 1'b0;
            endcase
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign stall_cnt      = r_stall_cnt;

endmodule
